// File: rtl/apb2mmio_wait.sv
// apb2mmio_wait: APB4 completer bridging onto a simple MMIO request/ack port.
// Each APB transfer is captured in its setup phase. In-window addresses produce a
// one-cycle MMIO read or write request, and PREADY is held off until the target acks.
// Out-of-window addresses are answered directly with PSLVERR and never reach the target.
// Optional feature macro: APB2MMIO_TIMEOUT_EN. When it is defined, a transfer that
// gets no ack within TIMEOUT cycles of its request ends with PSLVERR.
module apb2mmio_wait #(
    parameter int unsigned        A_WIDTH   = 32,
    parameter int unsigned        D_WIDTH   = 32,
    parameter logic [A_WIDTH-1:0] BASE_ADDR = '0,
    parameter longint unsigned    ADDR_SPAN = 64'h1000,
    parameter int unsigned        TIMEOUT   = 255
) (
    input  logic                   pclk_i,
    input  logic                   presetn_i,
    input  logic                   psel_i,
    input  logic [A_WIDTH-1:0]     paddr_i,
    input  logic                   pwrite_i,
    input  logic [D_WIDTH-1:0]     pwdata_i,
    input  logic [D_WIDTH/8-1:0]   pstrb_i,
    input  logic                   penable_i,
    output logic [D_WIDTH-1:0]     prdata_o,
    output logic                   pready_o,
    output logic                   pslverr_o,
    output logic                   wr_en_o,
    output logic [A_WIDTH-1:0]     wr_addr_o,
    output logic [D_WIDTH-1:0]     wr_data_o,
    output logic [D_WIDTH/8-1:0]   wr_strb_o,
    output logic                   rd_en_o,
    output logic [A_WIDTH-1:0]     rd_addr_o,
    input  logic [D_WIDTH-1:0]     rd_data_i,
    input  logic                   ack_i,
    input  logic                   err_i
);

    // Window size widened by one bit so that a span of 2^A_WIDTH still compares correctly.
    localparam logic [A_WIDTH:0] SPAN_EXT = (A_WIDTH+1)'(ADDR_SPAN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state;
    logic               write_q;
    logic [A_WIDTH-1:0] offset;
    logic               in_window;
    logic               setup;
    logic               expired;

    // The offset wraps modulo 2^A_WIDTH. Addresses below BASE_ADDR therefore become
    // large offsets and fail the window test.
    assign offset    = paddr_i - BASE_ADDR;
    assign in_window = ({1'b0, offset} < SPAN_EXT);
    assign setup     = psel_i & ~penable_i;

`ifdef APB2MMIO_TIMEOUT_EN
    // The counter holds 0 during the request cycle.
    // It expires on the TIMEOUT-th cycle spent in REQ/WAIT.
    localparam int unsigned        CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    assign expired = (wait_cnt == CNT_LAST);

    // Count cycles spent waiting for the target, and clear the count whenever no request is outstanding.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            wait_cnt <= '0;
        end else if (state == REQ || state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    logic unused_timeout;

    assign expired        = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Transfer sequencer: setup capture, request pulse, wait for ack, then one response cycle.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            prdata_o  <= '0;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            wr_strb_o <= '0;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
        end else begin
            // Request and response strobes are single-cycle pulses by default.
            wr_en_o   <= 1'b0;
            rd_en_o   <= 1'b0;
            pready_o  <= 1'b0;
            pslverr_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (setup) begin
                        write_q <= pwrite_i;
                        if (in_window) begin
                            state   <= REQ;
                            wr_en_o <= pwrite_i;
                            rd_en_o <= ~pwrite_i;
                            if (pwrite_i) begin
                                wr_addr_o <= offset;
                                wr_data_o <= pwdata_i;
                                wr_strb_o <= pstrb_i;
                            end else begin
                                rd_addr_o <= offset;
                                wr_strb_o <= '0;
                            end
                        end else begin
                            // Decode miss: no backend access, answer with an error next cycle.
                            state     <= RESP;
                            pready_o  <= 1'b1;
                            pslverr_o <= 1'b1;
                            prdata_o  <= '0;
                        end
                    end
                end

                REQ, WAIT: begin
                    // The ack is already honoured in the request cycle.
                    // If an ack and the timeout expiry coincide, the ack wins.
                    if (ack_i) begin
                        state     <= RESP;
                        pready_o  <= 1'b1;
                        pslverr_o <= err_i;
                        prdata_o  <= (write_q || err_i) ? '0 : rd_data_i;
                    end else if (expired) begin
                        state     <= RESP;
                        pready_o  <= 1'b1;
                        pslverr_o <= 1'b1;
                        prdata_o  <= '0;
                    end else begin
                        state <= WAIT;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb2mmio_wait.sv
// tb_apb2mmio_wait: directed APB transfers against apb2mmio_wait.
// The stimulus pushes the expected MMIO requests and APB responses into queues,
// and monitors compare them whenever the DUT raises a request or pready.
module tb_apb2mmio_wait;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] SPAN = 32'h0000_1000;
    localparam int unsigned TMO  = 4;

    logic        clk = 1'b0;
    logic        presetn;
    logic        psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        penable;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic [3:0]  wr_strb_o;
    logic        rd_en_o;
    logic [31:0] rd_addr_o;
    logic [31:0] rd_data;
    logic        ack;
    logic        err;

    always #5 clk = ~clk;

    apb2mmio_wait #(
        .A_WIDTH  (32),
        .D_WIDTH  (32),
        .BASE_ADDR(BASE),
        .ADDR_SPAN(64'h1000),
        .TIMEOUT  (TMO)
    ) dut (
        .pclk_i   (clk),
        .presetn_i(presetn),
        .psel_i   (psel),
        .paddr_i  (paddr),
        .pwrite_i (pwrite),
        .pwdata_i (pwdata),
        .pstrb_i  (pstrb),
        .penable_i(penable),
        .prdata_o (prdata_o),
        .pready_o (pready_o),
        .pslverr_o(pslverr_o),
        .wr_en_o  (wr_en_o),
        .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o),
        .wr_strb_o(wr_strb_o),
        .rd_en_o  (rd_en_o),
        .rd_addr_o(rd_addr_o),
        .rd_data_i(rd_data),
        .ack_i    (ack),
        .err_i    (err)
    );

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic        chk_data;
        logic [31:0] data;
        string       name;
    } rsp_t;

    typedef struct {
        int unsigned cyc;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        string       name;
    } req_t;

    rsp_t        rsp_q[$];
    req_t        req_q[$];
    rsp_t        mr;
    req_t        mq;
    int          checks = 0;
    int          passed = 0;
    int unsigned cyc    = 0;
    bit          seen;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Response monitor
    always @(negedge clk) begin
        if (presetn && pready_o) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_pready", 64'd1, 64'd0);
            end else begin
                mr = rsp_q.pop_front();
                check({mr.name, "_pready_cycle"}, 64'(cyc), 64'(mr.cyc));
                check({mr.name, "_pslverr"}, 64'(pslverr_o), 64'(mr.err));
                if (mr.chk_data) check({mr.name, "_prdata"}, 64'(prdata_o), 64'(mr.data));
            end
        end
    end

    // Request monitor
    always @(negedge clk) begin
        if (presetn && (wr_en_o || rd_en_o)) begin
            if (req_q.size() == 0) begin
                check("unexpected_mmio_req", 64'd1, 64'd0);
            end else begin
                mq = req_q.pop_front();
                check({mq.name, "_req_cycle"}, 64'(cyc), 64'(mq.cyc));
                check({mq.name, "_wr_en"}, 64'(wr_en_o), 64'(mq.wr));
                check({mq.name, "_rd_en"}, 64'(rd_en_o), 64'(!mq.wr));
                check({mq.name, "_addr"}, 64'(mq.wr ? wr_addr_o : rd_addr_o), 64'(mq.addr));
                check({mq.name, "_strb"}, 64'(wr_strb_o), 64'(mq.strb));
                if (mq.wr) check({mq.name, "_wdata"}, 64'(wr_data_o), 64'(mq.data));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (pready_o) seen = 1'b1;
    endtask

    function automatic int out_bits();
        return $countones({prdata_o, pready_o, pslverr_o, wr_en_o, wr_addr_o, wr_data_o,
                           wr_strb_o, rd_en_o, rd_addr_o});
    endfunction

    // dly < 0 means the target never acks.
    task automatic xfer(string name, logic wr, logic [31:0] addr, logic [31:0] wdata,
                        logic [3:0] strb, int dly, logic aerr, logic [31:0] rdat,
                        logic [31:0] exp_prdata);
        int unsigned t0;
        logic        inwin;
        rsp_t        r;
        req_t        q;
        int          n;
        step();
        seen    = 1'b0;
        t0      = cyc;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        inwin   = ((addr - BASE) < SPAN);
        r.name     = name;
        r.chk_data = !wr;
        r.data     = exp_prdata;
        if (!inwin) begin
            r.cyc = t0 + 1;
            r.err = 1'b1;
        end else if (dly < 0) begin
            r.cyc = t0 + 1 + TMO;
            r.err = 1'b1;
        end else begin
            r.cyc = t0 + 2 + unsigned'(dly);
            r.err = aerr;
        end
        rsp_q.push_back(r);
        if (inwin) begin
            q.name = name;
            q.cyc  = t0 + 1;
            q.wr   = wr;
            q.addr = addr - BASE;
            q.data = wdata;
            q.strb = wr ? strb : 4'h0;
            req_q.push_back(q);
        end
        step();
        penable = 1'b1;
        if (inwin && dly >= 0) begin
            for (int d = 0; d < dly; d++) step();
            ack     = 1'b1;
            err     = aerr;
            rd_data = rdat;
            step();
            ack     = 1'b0;
            err     = 1'b0;
            rd_data = 32'h0;
        end
        n = 0;
        while (!seen && n < 30) begin
            step();
            n++;
        end
        if (!seen) check({name, "_pready_arrived"}, 64'd0, 64'd1);
    endtask

    // Issue a read and leave the bridge waiting in WAIT with no ack given.
    task automatic start_read_no_ack(string name, logic [31:0] addr);
        req_t q;
        step();
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = addr;
        pstrb   = 4'h0;
        q.name  = name;
        q.cyc   = cyc + 1;
        q.wr    = 1'b0;
        q.addr  = addr - BASE;
        q.data  = 32'h0;
        q.strb  = 4'h0;
        req_q.push_back(q);
        step();
        penable = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        paddr   = 32'h0;
        pwrite  = 1'b0;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
        rd_data = 32'h0;
        ack     = 1'b0;
        err     = 1'b0;
        step();
        step();
        check("reset_outputs_zero_bits", 64'(out_bits()), 64'd0);
        presetn = 1'b1;

        xfer("t1_wr",      1'b1, 32'h1004, 32'hA5A5A5A5, 4'hF, 0, 1'b0, 32'h0, 32'h0);
        xfer("t2_rd",      1'b0, 32'h1008, 32'h0, 4'h0, 3, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
        xfer("t3_oow_rd",  1'b0, 32'h3000, 32'h0, 4'h0, 0, 1'b0, 32'h0, 32'h0);
        xfer("t4_wr_err",  1'b1, 32'h1010, 32'h12345678, 4'h3, 1, 1'b1, 32'h0, 32'h0);
        xfer("last_byte",  1'b0, 32'h1FFC, 32'h0, 4'h0, 0, 1'b0, 32'h0BADF00D, 32'h0BADF00D);
        xfer("below_base", 1'b0, 32'h0FFC, 32'h0, 4'h0, 0, 1'b0, 32'h0, 32'h0);
        xfer("rd_ok",      1'b0, 32'h1100, 32'h0, 4'h0, 2, 1'b0, 32'h11223344, 32'h11223344);
        xfer("rd_err",     1'b0, 32'h1104, 32'h0, 4'h0, 0, 1'b1, 32'h55667788, 32'h0);

        // An ack while idle must not produce a response.
        step();
        psel    = 1'b0;
        penable = 1'b0;
        seen    = 1'b0;
        ack     = 1'b1;
        err     = 1'b1;
        repeat (3) step();
        ack = 1'b0;
        err = 1'b0;
        step();
        check("idle_ack_no_pready", 64'(seen), 64'd0);

`ifdef APB2MMIO_TIMEOUT_EN
        xfer("t6_timeout", 1'b0, 32'h1040, 32'h0, 4'h0, -1, 1'b0, 32'h0, 32'h0);
        // A late ack arriving in IDLE is ignored.
        step();
        psel = 1'b0;
        seen = 1'b0;
        ack  = 1'b1;
        step();
        ack = 1'b0;
        step();
        check("t6_late_ack_no_pready", 64'(seen), 64'd0);
        start_read_no_ack("t5_rd", 32'h1050);
`else
        start_read_no_ack("t6_rd", 32'h1040);
        seen = 1'b0;
        repeat (100) step();
        check("t6_no_timeout_pready", 64'(seen), 64'd0);
`endif

        // Asynchronous reset while waiting on the target.
        #2 presetn = 1'b0;
        #1 check("t5_async_reset_outputs", 64'(out_bits()), 64'd0);
        step();
        psel    = 1'b0;
        penable = 1'b0;
        step();
        presetn = 1'b1;
        seen    = 1'b0;
        ack     = 1'b1;
        rd_data = 32'hFFFF0000;
        repeat (4) step();
        ack = 1'b0;
        step();
        check("t5_ack_after_reset_no_pready", 64'(seen), 64'd0);

        xfer("post_reset_rd", 1'b0, 32'h1004, 32'h0, 4'h0, 2, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D);
        step();
        psel    = 1'b0;
        penable = 1'b0;
        step();
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        check("req_queue_drained", 64'(req_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
